// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM requesters (CPU = m0, LT24 DMA = m1)
// and the single-port on-chip RAM that the arbiter multiplexes onto.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    // CPU data master
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_write;
    logic [BE_W-1:0]   m0_byteenable;
    logic [DATA_W-1:0] m0_writedata;
    logic              m0_waitrequest;
    logic [DATA_W-1:0] m0_readdata;
    logic              m0_readdatavalid;

    // LT24 frame-pixel DMA master
    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_write;
    logic [BE_W-1:0]   m1_byteenable;
    logic [DATA_W-1:0] m1_writedata;
    logic              m1_waitrequest;
    logic [DATA_W-1:0] m1_readdata;
    logic              m1_readdatavalid;

    // RAM port
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    // Arbiter side: slave to both requesters, drives the RAM
    modport slave (
        input  m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata
    );

    // Environment side: the requesters plus the RAM itself
    modport master (
        output m0_address, m0_read, m0_write, m0_byteenable, m0_writedata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_address, m1_read, m1_write, m1_byteenable, m1_writedata,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter for the single-port on-chip RAM.
// The grant is combinational so a request is accepted in the cycle it is
// presented; the DMA (m1) is protected from starvation by a stall counter
// that forces its grant after MAX_WAIT consecutive stalled cycles. Read data
// is steered back to its owner one cycle after acceptance.
module onchip_mem_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    onchip_mem_arbiter_if.slave  bus
);
    localparam logic [7:0] FORCE_AT = 8'(MAX_WAIT - 1);

    // Stall counter saturates instead of wrapping so force1 can never be missed.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              req0, req1;
    logic              grant0, grant1;
    logic              stalled1;
    logic              vld0, vld1;

    logic              last_q, last_d;
    logic [7:0]        wait1_q, wait1_d;
    logic              force1_q, force1_d;
    logic [1:0]        rd_owner_q, rd_owner_d;

    logic [ADDR_W-1:0] addr_sel;
    logic [BE_W-1:0]   be_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              write_sel;

    assign req0     = bus.m0_read | bus.m0_write;
    assign req1     = bus.m1_read | bus.m1_write;
    assign stalled1 = req1 & ~grant1;

    // Grant: forced DMA first, then sole requester, then the one not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (req1 && (force1_q || !req0 || !last_q)) begin
                grant1 = 1'b1;
            end else if (req0) begin
                grant0 = 1'b1;
            end
        end
    end

    // RAM mux: granted master's command, all zero when idle.
    always_comb begin
        addr_sel  = '0;
        be_sel    = '0;
        wdata_sel = '0;
        write_sel = 1'b0;
        if (grant0) begin
            addr_sel  = bus.m0_address;
            be_sel    = bus.m0_byteenable;
            wdata_sel = bus.m0_writedata;
            write_sel = bus.m0_write;
        end else if (grant1) begin
            addr_sel  = bus.m1_address;
            be_sel    = bus.m1_byteenable;
            wdata_sel = bus.m1_writedata;
            write_sel = bus.m1_write;
        end
    end

    assign bus.mem_address    = addr_sel;
    assign bus.mem_byteenable = be_sel;
    assign bus.mem_writedata  = wdata_sel;
    assign bus.mem_write      = write_sel;
    assign bus.mem_chipselect = grant0 | grant1;
    assign bus.mem_clken      = reset_n;

    assign bus.m0_waitrequest = ~grant0;
    assign bus.m1_waitrequest = ~grant1;

    // Return path is masked by reset so an in-flight read is dropped.
    assign vld0 = reset_n & rd_owner_q[0];
    assign vld1 = reset_n & rd_owner_q[1];
    assign bus.m0_readdatavalid = vld0;
    assign bus.m1_readdatavalid = vld1;
    assign bus.m0_readdata      = vld0 ? bus.mem_readdata : '0;
    assign bus.m1_readdata      = vld1 ? bus.mem_readdata : '0;

    // Next state: priority pointer, starvation tracking, read ownership.
    always_comb begin
        last_d   = last_q;
        wait1_d  = 8'd0;
        force1_d = force1_q;
        if (grant0 || grant1) begin
            last_d = grant1;
        end
        if (stalled1) begin
            wait1_d = sat_inc8(wait1_q);
        end
        if (grant1) begin
            force1_d = 1'b0;
        end else if (stalled1 && (wait1_q == FORCE_AT)) begin
            force1_d = 1'b1;
        end
        // A simultaneous read+write is treated as a write: no read response.
        rd_owner_d = {grant1 & bus.m1_read & ~bus.m1_write,
                      grant0 & bus.m0_read & ~bus.m0_write};
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q     <= 1'b0;
            wait1_q    <= 8'd0;
            force1_q   <= 1'b0;
            rd_owner_q <= 2'b00;
        end else begin
            last_q     <= last_d;
            wait1_q    <= wait1_d;
            force1_q   <= force1_d;
            rd_owner_q <= rd_owner_d;
        end
    end
endmodule
